// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LSU memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Fetches always read a full word.
    localparam logic [3:0] FETCH_BMASK = 4'hF;

    // Wide enough for STARVE_MAX up to 15 and TIMEOUT up to 1023.
    localparam int STARVE_W = 4;
    localparam int WD_W     = 10;

    // Response word handed to the owner: zero when the watchdog aborted.
    function automatic logic [31:0] resp_data(input logic abort, input logic [31:0] rdata);
        return abort ? 32'd0 : rdata;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Response watchdog: cleared when a transaction is issued, counts every
// cycle spent waiting, and flags the wait cycle on which the count would
// reach TIMEOUT-1 so the arbiter can abort on that edge.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam logic [WD_W-1:0] LAST_WAIT = WD_W'(TIMEOUT - 2);
    localparam logic [WD_W-1:0] TOP_COUNT = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_cnt;

    // Wait-cycle counter; holds at its top value instead of wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != TOP_COUNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = i_enable && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: LSU data accesses win by
// default, fetch is forced through after STARVE_MAX consecutive data grants,
// one transaction is outstanding at a time, and a watchdog aborts a
// transaction whose response never arrives.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic [31:0] i_dm_addr,
    input  logic        i_dm_wren,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_bmask,
    output logic        o_dm_gnt,
    output logic        o_dm_rvalid,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    owner_t              w_owner;
    logic [STARVE_W-1:0] r_starve;
    logic                r_drop;
    logic                r_if_rvalid;
    logic                r_dm_rvalid;
    logic                r_err;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_dm_rdata;

    logic                w_eff_if;
    logic                w_starved;
    logic                w_grant;
    logic                w_wd_timeout;
    logic                w_done;
    logic                w_abort;
    logic                w_if_deliver;
    logic                w_dm_deliver;
    logic [31:0]         w_resp_data;

    // A fetch is never issued while the pipeline is redirecting.
    assign w_eff_if  = i_if_req && !i_if_flush;
    assign w_starved = (r_starve == STARVE_W'(STARVE_MAX));

    // Completion of the outstanding transaction: a response, or a watchdog
    // abort (the watchdog only counts outside IDLE, so it cannot fire there).
    assign w_done      = (r_state != IDLE) && (i_mem_rvalid || w_wd_timeout);
    assign w_abort     = w_wd_timeout && !i_mem_rvalid;
    assign w_resp_data = resp_data(w_abort, i_mem_rdata);

    // A flush seen earlier in the wait, or on the response cycle, swallows the fetch data.
    assign w_if_deliver = (r_state == WAIT_IF) && w_done && !r_drop && !i_if_flush;
    assign w_dm_deliver = (r_state == WAIT_DM) && w_done;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_grant),
        .i_enable  (r_state != IDLE),
        .o_timeout (w_wd_timeout)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: issue from IDLE on a grant, return on response or abort.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_next = (w_owner == OWN_IF) ? WAIT_IF : WAIT_DM;
            WAIT_IF: if (w_done)  w_state_next = IDLE;
            WAIT_DM: if (w_done)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs: winner selection and memory request, only driven in IDLE.
    always_comb begin
        w_owner     = OWN_DM;
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wren  = 1'b0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if ((r_state == IDLE) && !i_reset) begin
            if (w_eff_if && (!i_dm_req || w_starved)) begin
                w_owner     = OWN_IF;
                o_mem_req   = 1'b1;
                o_mem_addr  = i_if_addr;
                o_mem_bmask = FETCH_BMASK;
            end else if (i_dm_req) begin
                w_owner     = OWN_DM;
                o_mem_req   = 1'b1;
                o_mem_addr  = i_dm_addr;
                o_mem_wren  = i_dm_wren;
                o_mem_wdata = i_dm_wdata;
                o_mem_bmask = i_dm_bmask;
            end
        end
        w_grant  = o_mem_req && i_mem_ready;
        o_if_gnt = w_grant && (w_owner == OWN_IF);
        o_dm_gnt = w_grant && (w_owner == OWN_DM);
    end

    // Starvation count: consecutive data grants that bypassed a waiting fetch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if ((w_owner == OWN_DM) && w_eff_if) begin
                if (!w_starved) r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
        end
    end

    // Drop flag: remembers a flush that landed while the fetch was in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drop <= 1'b0;
        end else if ((r_state != WAIT_IF) || w_done) begin
            r_drop <= 1'b0;
        end else if (i_if_flush) begin
            r_drop <= 1'b1;
        end
    end

    // Response registers: one-cycle valid pulses, data held until the next delivery.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_if_deliver;
            r_dm_rvalid <= w_dm_deliver;
            r_err       <= w_done && w_abort;
            if (w_if_deliver) r_if_rdata <= w_resp_data;
            if (w_dm_deliver) r_dm_rdata <= w_resp_data;
        end
    end

    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rvalid = r_dm_rvalid;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_err       = r_err;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters: the IF-stage instruction fetch and the MEM-stage LSU data access.
- Allows one outstanding memory transaction at a time.
- Data requests have priority. A starvation counter guarantees forward progress for fetch.
- The IF side supports a flush that drops a stale in-flight fetch. A watchdog recovers from a memory that never responds.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while a fetch is pending before fetch is forced to win; legal range 1..15.
- TIMEOUT, 255: maximum cycles spent waiting for i_mem_rvalid before abort; legal range 2..1023.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_if_req  in  1  fetch request; held until o_if_gnt.
- i_if_addr  in  32  fetch byte address.
- i_if_flush  in  1  pipeline redirect; kills the pending or in-flight fetch.
- o_if_gnt  out  1  fetch accepted by memory this cycle.
- o_if_rvalid  out  1  fetch data valid (1-cycle pulse).
- o_if_rdata  out  32  fetched instruction.
- i_dm_req  in  1  data request; held until o_dm_gnt.
- i_dm_addr  in  32  data byte address.
- i_dm_wren  in  1  1 = store, 0 = load.
- i_dm_wdata  in  32  store data.
- i_dm_bmask  in  4  store byte enables.
- o_dm_gnt  out  1  data request accepted this cycle.
- o_dm_rvalid  out  1  load data or store ack valid (1-cycle pulse).
- o_dm_rdata  out  32  load data.
- o_mem_req  out  1  request to memory.
- o_mem_addr  out  32  memory address.
- o_mem_wren  out  1  memory write enable.
- o_mem_wdata  out  32  memory write data.
- o_mem_bmask  out  4  memory byte enables; 4'hF for fetch.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_rvalid  in  1  response or write-ack valid.
- i_mem_rdata  in  32  response data.
- o_err  out  1  1-cycle pulse when a watchdog abort occurs.

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE.
  - Starvation count, watchdog count and drop flag are 0.
  - o_if_rvalid, o_dm_rvalid and o_err are 0; o_if_rdata and o_dm_rdata are 0.
  - o_mem_req is forced 0 while i_reset is high.
- States: IDLE, WAIT_IF, WAIT_DM.
- Effective fetch request: eff_if = i_if_req & ~i_if_flush. A fetch is never issued in a flush cycle.
- IDLE winner selection:
  - Default winner is DM when i_dm_req is high.
  - Winner is IF when eff_if is high and either i_dm_req is low or starve_cnt == STARVE_MAX.
- o_mem_req and o_mem_* are combinational from the winner's inputs. They are valid only in IDLE; elsewhere o_mem_req = 0 and the other o_mem_* outputs are 0.
- Grant:
  - When o_mem_req & i_mem_ready, the winner's gnt pulses combinationally in the same cycle.
  - The FSM moves to WAIT_IF or WAIT_DM.
  - Without i_mem_ready, nothing is granted; the selection is re-evaluated next cycle.
- Starvation count:
  - On a DM grant with eff_if high: starve_cnt increments, saturating at STARVE_MAX.
  - On an IF grant, or a DM grant with eff_if low: starve_cnt clears to 0.
- WAIT_x on i_mem_rvalid:
  - x_rdata is registered from i_mem_rdata.
  - o_x_rvalid pulses in the next cycle.
  - The FSM returns to IDLE on the same edge.
  - A new grant may occur in the cycle rvalid pulses, giving back-to-back throughput of 1 transaction per 2 cycles minimum.
- Store ack: o_dm_rvalid pulses for stores; o_dm_rdata then carries i_mem_rdata and is don't-care.
- Flush:
  - i_if_flush in WAIT_IF sets drop = 1.
  - The fetch response still completes the transaction, but o_if_rvalid is suppressed and o_if_rdata is not updated.
  - drop clears when leaving WAIT_IF.
  - i_if_flush in the same cycle as i_mem_rvalid also drops the response.
  - i_if_flush has no effect in WAIT_DM.
- Watchdog:
  - wd_cnt clears on entry to WAIT_*, then increments each cycle in WAIT_*.
  - If wd_cnt reaches TIMEOUT-1 without i_mem_rvalid: o_err pulses next cycle, and the owner's rvalid pulses in that cycle with rdata = 0 (the IF rvalid is suppressed if drop is set).
  - The FSM returns to IDLE on that edge.
  - A late i_mem_rvalid arriving in IDLE is ignored.
- i_mem_rvalid in IDLE is always ignored.
- Reset mid-transaction: the outstanding transaction is abandoned, and no rvalid is produced for it after reset release.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, WAIT_IF, WAIT_DM}.
  - owner_t enum {OWN_IF, OWN_DM}.
  - Constant FETCH_BMASK = 4'hF.
- One sub-module, mem_arb_watchdog: a loadable counter with clear, enable, and a timeout flag output, parameterised by TIMEOUT.

Test Plan:
- Single fetch: if_req, addr 0x100, ready = 1; memory rvalid 2 cycles later with 0x00500093 -> o_if_gnt pulses in the request cycle; o_if_rvalid pulses 1 cycle after mem rvalid with o_if_rdata = 0x00500093; o_mem_bmask = 4'hF.
- Simultaneous if_req and dm_req (load 0x2000), starve_cnt = 0 -> DM granted first; the fetch is granted in the cycle o_dm_rvalid pulses.
- Starvation: with STARVE_MAX = 4, dm_req held high continuously while if_req is held high -> grants go DM ×4, then IF, then DM again; starve_cnt returns to 0 after the IF grant.
- Flush in WAIT_IF, 1 cycle after grant; memory returns 0xDEADBEEF -> no o_if_rvalid; o_if_rdata unchanged; the next fetch issues normally.
- Timeout: with TIMEOUT = 8, a store is granted and memory never responds -> o_err and o_dm_rvalid pulse together 8 cycles after the grant; the state is IDLE; a late i_mem_rvalid produces no response.
- Reset asserted asynchronously in WAIT_DM -> outputs are immediately at reset values; after release, no o_dm_rvalid appears, and a fresh fetch completes normally.
